// File: rtl/rs_window.sv
// DEPTH-entry reservation station: dispatch insert, tag wakeup, oldest-ready
// select via an age matrix, valid/ready issue and synchronous flush.
module rs_window #(
    parameter int BWIDTH = 57,
    parameter int DEPTH  = 4,
    parameter int RBITS  = 6,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_ins_valid,
    output logic                  o_ins_ready,
    input  logic [BWIDTH-1:0]     i_ins_bundle,
    input  logic [RBITS-1:0]      i_ins_rs1,
    input  logic [RBITS-1:0]      i_ins_rs2,
    input  logic                  i_ins_use1,
    input  logic                  i_ins_use2,
    input  logic                  i_ins_rdy1,
    input  logic                  i_ins_rdy2,
    input  logic [2**RBITS-1:0]   i_rdy_regs,
    output logic                  o_issue_valid,
    input  logic                  i_issue_ready,
    output logic [BWIDTH-1:0]     o_issue_bundle,
    output logic [CW-1:0]         o_count
);

    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  rdy1_q;
    logic [DEPTH-1:0]  rdy2_q;
    logic [RBITS-1:0]  rs1_q    [DEPTH];
    logic [RBITS-1:0]  rs2_q    [DEPTH];
    logic [BWIDTH-1:0] bundle_q [DEPTH];
    logic [DEPTH-1:0]  older    [DEPTH];   // older[i][j]: i entered before j
    logic [CW-1:0]     count_q;

    logic [DEPTH-1:0]  eligible;
    logic [DEPTH-1:0]  sel;
    logic [DEPTH-1:0]  free_oh;
    logic [BWIDTH-1:0] sel_bundle;
    logic              ins_fire;
    logic              iss_fire;

    assign eligible      = vld & rdy1_q & rdy2_q;
    // Lowest clear bit of vld, as a one-hot.
    assign free_oh       = ~vld & (vld + DEPTH'(1));
    assign o_ins_ready   = (count_q != CW'(DEPTH));
    assign o_issue_valid = |eligible;
    assign o_issue_bundle = sel_bundle;
    assign o_count       = count_q;
    assign ins_fire      = i_ins_valid & o_ins_ready & ~i_flush;
    assign iss_fire      = o_issue_valid & i_issue_ready & ~i_flush;

    always_comb begin
        sel        = '0;
        sel_bundle = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel[i] = eligible[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (eligible[j] && older[j][i]) begin
                    sel[i] = 1'b0;
                end
            end
            if (sel[i]) begin
                sel_bundle = sel_bundle | bundle_q[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld     <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rs1_q[i]    <= '0;
                rs2_q[i]    <= '0;
                bundle_q[i] <= '0;
                older[i]    <= '0;
            end
        end else if (i_flush) begin
            vld     <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ins_fire && free_oh[i]) begin
                    vld[i]      <= 1'b1;
                    rdy1_q[i]   <= ~i_ins_use1 | i_ins_rdy1 | i_rdy_regs[i_ins_rs1];
                    rdy2_q[i]   <= ~i_ins_use2 | i_ins_rdy2 | i_rdy_regs[i_ins_rs2];
                    rs1_q[i]    <= i_ins_rs1;
                    rs2_q[i]    <= i_ins_rs2;
                    bundle_q[i] <= i_ins_bundle;
                    older[i]    <= '0;
                end else begin
                    if (iss_fire && sel[i]) begin
                        vld[i] <= 1'b0;
                    end
                    rdy1_q[i] <= rdy1_q[i] | i_rdy_regs[rs1_q[i]];
                    rdy2_q[i] <= rdy2_q[i] | i_rdy_regs[rs2_q[i]];
                    // Every currently valid entry, issuing or not, is older than the newcomer.
                    if (ins_fire && vld[i]) begin
                        older[i] <= older[i] | free_oh;
                    end
                end
            end
            count_q <= count_q + CW'(ins_fire) - CW'(iss_fire);
        end
    end

endmodule

// File: tb/tb_rs_window.sv
// Randomized and directed bench for rs_window against an age-ordered queue model.
module tb_rs_window;

    localparam int BW    = 57;
    localparam int DEPTH = 4;
    localparam int RB    = 6;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_flush;
    logic          i_ins_valid;
    logic          o_ins_ready;
    logic [BW-1:0] i_ins_bundle;
    logic [RB-1:0] i_ins_rs1;
    logic [RB-1:0] i_ins_rs2;
    logic          i_ins_use1;
    logic          i_ins_use2;
    logic          i_ins_rdy1;
    logic          i_ins_rdy2;
    logic [63:0]   i_rdy_regs;
    logic          o_issue_valid;
    logic          i_issue_ready;
    logic [BW-1:0] o_issue_bundle;
    logic [2:0]    o_count;

    rs_window #(.BWIDTH(BW), .DEPTH(DEPTH), .RBITS(RB)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_ins_valid   (i_ins_valid),
        .o_ins_ready   (o_ins_ready),
        .i_ins_bundle  (i_ins_bundle),
        .i_ins_rs1     (i_ins_rs1),
        .i_ins_rs2     (i_ins_rs2),
        .i_ins_use1    (i_ins_use1),
        .i_ins_use2    (i_ins_use2),
        .i_ins_rdy1    (i_ins_rdy1),
        .i_ins_rdy2    (i_ins_rdy2),
        .i_rdy_regs    (i_rdy_regs),
        .o_issue_valid (o_issue_valid),
        .i_issue_ready (i_issue_ready),
        .o_issue_bundle(o_issue_bundle),
        .o_count       (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [BW-1:0] b;
        int unsigned   rs1;
        int unsigned   rs2;
        bit            r1;
        bit            r2;
    } ent_t;

    ent_t mq[$];   // oldest first
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_ready();
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].r1 && mq[k].r2) return k;
        end
        return -1;
    endfunction

    // Called at a falling edge: compare against the model, drive, advance one cycle.
    task automatic step(input bit fl, input bit iv, input logic [BW-1:0] b,
                        input int unsigned a1, input int unsigned a2,
                        input bit u1, input bit u2, input bit r1, input bit r2,
                        input logic [63:0] regs, input bit ir);
        int fr;
        bit do_ins;
        ent_t e;
        fr = first_ready();
        check("count", 64'(o_count), 64'(mq.size()));
        check("ins_ready", 64'(o_ins_ready), 64'(mq.size() < DEPTH));
        check("issue_valid", 64'(o_issue_valid), 64'(fr >= 0));
        check("issue_bundle", 64'(o_issue_bundle), (fr >= 0) ? 64'(mq[fr].b) : 64'd0);
        i_flush = fl; i_ins_valid = iv; i_ins_bundle = b;
        i_ins_rs1 = RB'(a1); i_ins_rs2 = RB'(a2);
        i_ins_use1 = u1; i_ins_use2 = u2; i_ins_rdy1 = r1; i_ins_rdy2 = r2;
        i_rdy_regs = regs; i_issue_ready = ir;
        @(posedge i_clk);
        if (fl) begin
            mq.delete();
        end else begin
            do_ins = iv && (mq.size() < DEPTH);
            if (ir && fr >= 0) mq.delete(fr);
            foreach (mq[k]) begin
                mq[k].r1 = mq[k].r1 | regs[mq[k].rs1];
                mq[k].r2 = mq[k].r2 | regs[mq[k].rs2];
            end
            if (do_ins) begin
                e.b = b; e.rs1 = a1 % 64; e.rs2 = a2 % 64;
                e.r1 = !u1 || r1 || regs[a1 % 64];
                e.r2 = !u2 || r2 || regs[a2 % 64];
                mq.push_back(e);
            end
        end
        @(negedge i_clk);
    endtask

    task automatic idle(input bit ir, input logic [63:0] regs);
        step(0, 0, '0, 0, 0, 0, 0, 0, 0, regs, ir);
    endtask

    task automatic ins(input logic [BW-1:0] b, input int unsigned a1, input bit u1,
                       input logic [63:0] regs);
        step(0, 1, b, a1, 0, u1, 0, 0, 0, regs, 0);
    endtask

    logic [BW-1:0] bA, bB, bC, bX, b5;
    logic [63:0]   rr;

    initial begin
        i_rst_n = 1'b0; i_flush = 0; i_ins_valid = 0; i_ins_bundle = '0;
        i_ins_rs1 = '0; i_ins_rs2 = '0; i_ins_use1 = 0; i_ins_use2 = 0;
        i_ins_rdy1 = 0; i_ins_rdy2 = 0; i_rdy_regs = '0; i_issue_ready = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_ins_ready", 64'(o_ins_ready), 64'd1);
        check("rst_issue_valid", 64'(o_issue_valid), 64'd0);
        check("rst_bundle", 64'(o_issue_bundle), 64'd0);

        // Fill with entries waiting on tag 5, then hold a fifth offer.
        for (int k = 0; k < 4; k++) ins(57'h0AB_0000 + 57'(k), 5, 1, '0);
        check("full_count", 64'(o_count), 64'd4);
        check("full_ins_ready", 64'(o_ins_ready), 64'd0);
        check("full_issue_valid", 64'(o_issue_valid), 64'd0);
        b5 = 57'h1_5555_0005;
        repeat (2) ins(b5, 0, 0, '0);
        check("held_count", 64'(o_count), 64'd4);
        // Broadcast tag 5 while the offer is still held.
        ins(b5, 0, 0, 64'd1 << 5);
        check("wake_valid", 64'(o_issue_valid), 64'd1);
        check("wake_oldest", 64'(o_issue_bundle), 64'h0AB_0000);
        // Full: issue and insert offered together, insert refused then accepted.
        step(0, 1, b5, 0, 0, 0, 0, 0, 0, '0, 1);
        check("conc_count", 64'(o_count), 64'd3);
        ins(b5, 0, 0, '0);
        check("conc_count2", 64'(o_count), 64'd4);
        repeat (4) idle(1, '0);
        check("drain_count", 64'(o_count), 64'd0);

        // Same-cycle broadcast captured on insert.
        bX = 57'h1_DEAD_BEEF;
        ins(bX, 9, 1, 64'd1 << 9);
        check("cap_valid", 64'(o_issue_valid), 64'd1);
        check("cap_bundle", 64'(o_issue_bundle), 64'(bX));
        idle(1, '0);

        // Age order.
        bA = 57'h0A; bB = 57'h0B; bC = 57'h0C;
        ins(bA, 7, 1, '0);
        ins(bB, 8, 1, '0);
        ins(bC, 0, 0, '0);
        check("age_c", 64'(o_issue_bundle), 64'h0C);
        idle(1, 64'd1 << 8);
        check("age_b", 64'(o_issue_bundle), 64'h0B);
        idle(1, '0);
        check("age_none", 64'(o_issue_valid), 64'd0);
        idle(0, 64'd1 << 7);
        check("age_a", 64'(o_issue_bundle), 64'h0A);
        idle(1, '0);
        check("age_count", 64'(o_count), 64'd0);

        // Flush with insert and issue handshakes in the same cycle.
        for (int k = 0; k < 3; k++) ins(57'h0F0 + 57'(k), 0, 0, '0);
        step(1, 1, 57'h0FF, 0, 0, 0, 0, 0, 0, '0, 1);
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_valid", 64'(o_issue_valid), 64'd0);
        idle(0, '0);

        // Asynchronous reset mid-cycle with 3 eligible entries.
        for (int k = 0; k < 3; k++) ins(57'h0E0 + 57'(k), 0, 0, '0);
        check("pre_rst_valid", 64'(o_issue_valid), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_count", 64'(o_count), 64'd0);
        check("arst_valid", 64'(o_issue_valid), 64'd0);
        check("arst_ins_ready", 64'(o_ins_ready), 64'd1);
        mq.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rr = '0;
            if ($urandom_range(0, 9) < 3) rr = 64'd1 << $urandom_range(0, 7);
            if ($urandom_range(0, 19) == 0) rr = {$urandom, $urandom} & {$urandom, $urandom};
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
                 {$urandom, $urandom}, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 rr, $urandom_range(0, 1));
        end
        idle(0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
